svm_seq_core: RTL and testbench



---
 rtl/svm_seq_pkg.sv | 19 +
 rtl/svm_seq_if.sv | 29 ++
 rtl/svm_seq_mac_unit.sv | 22 ++
 rtl/svm_seq_core.sv | 113 +++++++++++
 tb/tb_svm_seq_core.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/svm_seq_pkg.sv
// rtl/svm_seq_pkg.sv - shared types and default coefficients for the sequential SVM core
package svm_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } svm_state_e;

    localparam int SVM_NFEAT = 4;
    localparam int SVM_IW    = 4;
    localparam int SVM_WW    = 8;
    localparam int SVM_OW    = 13;

    // Entry i sits at bits [i*WW +: WW]: {73, 73, -73, -73} read from high to low.
    localparam logic [SVM_NFEAT*SVM_WW-1:0] SVM_W = 32'h4949_B7B7;
    localparam logic signed [SVM_OW-1:0]    SVM_B = 13'sd1170;

endpackage

// File: rtl/svm_seq_if.sv
// rtl/svm_seq_if.sv - feature-in / score-out handshake bundle for svm_seq_core
interface svm_seq_if
    import svm_seq_pkg::*;
#(
    parameter int NFEAT = SVM_NFEAT,
    parameter int IW    = SVM_IW,
    parameter int OW    = SVM_OW
) ();

    logic                  in_valid;
    logic                  in_ready;
    logic [NFEAT*IW-1:0]   inp;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [OW-1:0]  out;
    logic                  out_class;
    logic                  busy;

    modport master (
        output in_valid, inp, out_ready,
        input  in_ready, out_valid, out, out_class, busy
    );

    modport slave (
        input  in_valid, inp, out_ready,
        output in_ready, out_valid, out, out_class, busy
    );

endinterface

// File: rtl/svm_seq_mac_unit.sv
// rtl/svm_seq_mac_unit.sv - the single shared signed multiply-accumulate step
module svm_seq_mac_unit #(
    parameter int IW = 4,
    parameter int WW = 8,
    parameter int OW = 13
) (
    input  logic [IW-1:0]        feat,
    input  logic signed [WW-1:0] weight,
    input  logic signed [OW+1:0] acc,
    output logic signed [OW+1:0] sum
);

    localparam int PW  = WW + IW + 1;
    localparam int EXT = OW + 2 - PW;

    logic signed [PW-1:0] prod;

    // Features are unsigned; the zero MSB keeps them non-negative in the signed multiply.
    assign prod = $signed({1'b0, feat}) * weight;
    assign sum  = acc + $signed({{EXT{prod[PW-1]}}, prod});

endmodule

// File: rtl/svm_seq_core.sv
// rtl/svm_seq_core.sv - time-multiplexed linear SVM evaluator (SVM_SEQ_SAT_EN: clamp final score)
module svm_seq_core
    import svm_seq_pkg::*;
#(
    parameter int                      NFEAT   = SVM_NFEAT,
    parameter int                      IW      = SVM_IW,
    parameter int                      WW      = SVM_WW,
    parameter int                      OW      = SVM_OW,
    parameter logic [NFEAT*WW-1:0]     WEIGHTS = SVM_W,
    parameter logic signed [OW-1:0]    BIAS    = SVM_B
) (
    input  logic    clk,
    input  logic    rst_n,
    svm_seq_if.slave io
);

    localparam int IDXW = (NFEAT > 1) ? $clog2(NFEAT) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NFEAT - 1);

    localparam logic [1:0] S_IDLE = ST_IDLE;
    localparam logic [1:0] S_MAC  = ST_MAC;
    localparam logic [1:0] S_OUT  = ST_OUT;

    logic [1:0]            state;
    logic [IDXW-1:0]       idx;
    logic signed [OW+1:0]  acc;
    logic [NFEAT*IW-1:0]   feat_r;
    logic signed [OW-1:0]  out_r;
    logic                  cls_r;

    logic [IW-1:0]         feat_cur;
    logic signed [WW-1:0]  w_cur;
    logic signed [OW+1:0]  mac_sum;
    logic signed [OW+1:0]  bias_ext;
    logic signed [OW-1:0]  res;

    assign feat_cur = feat_r[idx*IW +: IW];
    assign w_cur    = WEIGHTS[idx*WW +: WW];
    assign bias_ext = {{2{BIAS[OW-1]}}, BIAS};

    svm_seq_mac_unit #(
        .IW (IW),
        .WW (WW),
        .OW (OW)
    ) u_mac (
        .feat   (feat_cur),
        .weight (w_cur),
        .acc    (acc),
        .sum    (mac_sum)
    );

    // Only the final sum is narrowed; the running accumulator keeps two guard bits.
`ifdef SVM_SEQ_SAT_EN
    localparam logic signed [OW+1:0] SAT_MAX = (OW+2)'((1 << (OW - 1)) - 1);
    localparam logic signed [OW+1:0] SAT_MIN = ~SAT_MAX;

    always_comb begin
        res = mac_sum[OW-1:0];
        if (mac_sum > SAT_MAX)
            res = SAT_MAX[OW-1:0];
        else if (mac_sum < SAT_MIN)
            res = SAT_MIN[OW-1:0];
    end
`else
    always_comb begin
        res = mac_sum[OW-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            idx    <= '0;
            acc    <= '0;
            feat_r <= '0;
            out_r  <= '0;
            cls_r  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (io.in_valid) begin
                        feat_r <= io.inp;
                        acc    <= bias_ext;
                        idx    <= '0;
                        state  <= S_MAC;
                    end
                end
                S_MAC: begin
                    acc <= mac_sum;
                    idx <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        out_r <= res;
                        cls_r <= ~res[OW-1];
                        idx   <= '0;
                        state <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (io.out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign io.in_ready  = (state == S_IDLE);
    assign io.out_valid = (state == S_OUT);
    assign io.busy      = (state == S_MAC) || (state == S_OUT);
    assign io.out       = out_r;
    assign io.out_class = cls_r;

endmodule

// File: tb/tb_svm_seq_core.sv
// tb/tb_svm_seq_core.sv - self-checking bench for svm_seq_core (honours SVM_SEQ_SAT_EN)
module tb_svm_seq_core;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    svm_seq_if dif ();
    svm_seq_if bif ();

    svm_seq_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (dif)
    );

    svm_seq_core #(
        .BIAS (13'sd4000)
    ) dut_bias (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (bif)
    );

    typedef struct {
        logic [15:0] inp;
        int          stall;
        int          exp_out;
        int          exp_cls;
    } vec_t;

    vec_t tbl[4];
    int   nvec = 0;
    int   nmis = 0;

    task automatic check(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: dot product in plain integers, then narrow to a 13-bit score.
    function automatic int model(input logic [15:0] v, input int bias);
        int w[4] = '{-73, -73, 73, 73};
        int s = bias;
        for (int i = 0; i < 4; i++)
            s += int'(v[i*4 +: 4]) * w[i];
`ifdef SVM_SEQ_SAT_EN
        if (s > 4095)  s = 4095;
        if (s < -4096) s = -4096;
`else
        s = ((s + 4096) & 8191) - 4096;
`endif
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_txn(input logic [15:0] v, input int stall, input bit pulse,
                          output int got, output int cls);
        int k;
        int lat;
        k = 0;
        while (!dif.in_ready && k < 20) begin
            step();
            k++;
        end
        check("in_ready_idle", int'(dif.in_ready), 1);
        dif.inp       = v;
        dif.in_valid  = 1'b1;
        dif.out_ready = 1'b0;
        step();
        dif.in_valid = 1'b0;
        dif.inp      = 16'($urandom);
        check("busy_after_accept", int'(dif.busy), 1);
        check("in_ready_low_mac", int'(dif.in_ready), 0);
        lat = 0;
        while (!dif.out_valid && lat < 20) begin
            step();
            lat++;
        end
        check("latency", lat, 4);
        got = int'($signed(dif.out));
        cls = int'(dif.out_class);
        for (int s = 0; s < stall; s++) begin
            check("stall_out_valid", int'(dif.out_valid), 1);
            check("stall_out_stable", int'($signed(dif.out)), got);
            check("stall_in_ready", int'(dif.in_ready), 0);
            dif.in_valid = pulse && (s == 1);
            dif.inp      = 16'h0000;
            step();
        end
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b1;
        step();
        dif.out_ready = 1'b0;
        check("out_valid_drop", int'(dif.out_valid), 0);
        check("in_ready_after_hs", int'(dif.in_ready), 1);
        if (pulse) begin
            step();
            check("stall_pulse_ignored", int'(dif.busy), 0);
        end
    endtask

    initial begin
        int          got;
        int          cls;
        int          e;
        int          k;
        int          exq[$];
        int          t_prev;
        int          nres;
        bit          acc_now;
        logic [15:0] v;

        tbl[0] = '{inp: 16'h0000, stall: 0, exp_out: 1170,  exp_cls: 1};
        tbl[1] = '{inp: 16'h00FF, stall: 1, exp_out: -1020, exp_cls: 0};
        tbl[2] = '{inp: 16'hFF00, stall: 0, exp_out: 3360,  exp_cls: 1};
        tbl[3] = '{inp: 16'hFFFF, stall: 2, exp_out: 1170,  exp_cls: 1};

        rst_n         = 1'b0;
        dif.in_valid  = 1'b0;
        dif.inp       = '0;
        dif.out_ready = 1'b0;
        bif.in_valid  = 1'b0;
        bif.inp       = '0;
        bif.out_ready = 1'b0;
        repeat (3) step();
        check("rst_out", int'($signed(dif.out)), 0);
        check("rst_out_valid", int'(dif.out_valid), 0);
        check("rst_out_class", int'(dif.out_class), 0);
        check("rst_busy", int'(dif.busy), 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", int'(dif.in_ready), 1);

        for (int i = 0; i < 4; i++) begin
            do_txn(tbl[i].inp, tbl[i].stall, 1'b0, got, cls);
            check($sformatf("tbl%0d_out", i), got, tbl[i].exp_out);
            check($sformatf("tbl%0d_class", i), cls, tbl[i].exp_cls);
        end

        do_txn(16'hFF00, 5, 1'b1, got, cls);
        check("bp_out", got, 3360);
        check("bp_class", cls, 1);

        repeat (30) begin
            v = 16'($urandom);
            do_txn(v, int'($urandom_range(0, 2)), 1'b0, got, cls);
            e = model(v, 1170);
            check($sformatf("rand_out_%h", v), got, e);
            check($sformatf("rand_class_%h", v), cls, (e >= 0) ? 1 : 0);
        end

        // Abort a transaction after its second MAC edge.
        dif.inp      = 16'hFFFF;
        dif.in_valid = 1'b1;
        step();
        dif.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", int'($signed(dif.out)), 0);
        check("mid_rst_out_valid", int'(dif.out_valid), 0);
        check("mid_rst_out_class", int'(dif.out_class), 0);
        check("mid_rst_busy", int'(dif.busy), 0);
        step();
        rst_n = 1'b1;
        step();
        check("mid_rst_in_ready", int'(dif.in_ready), 1);
        do_txn(16'h00FF, 0, 1'b0, got, cls);
        check("post_rst_out", got, -1020);
        check("post_rst_class", cls, 0);

        // Back-to-back with in_valid and out_ready held high.
        dif.out_ready = 1'b1;
        dif.in_valid  = 1'b1;
        v             = 16'($urandom);
        dif.inp       = v;
        nres          = 0;
        t_prev        = -1;
        for (int c = 0; c < 60 && nres < 4; c++) begin
            acc_now = dif.in_ready;
            if (dif.out_valid) begin
                if (exq.size() > 0) begin
                    e = exq.pop_front();
                    check("b2b_out", int'($signed(dif.out)), e);
                end else begin
                    check("b2b_unexpected_out", 1, 0);
                end
                if (t_prev >= 0)
                    check("b2b_gap", c - t_prev, 6);
                t_prev = c;
                nres++;
            end
            if (acc_now)
                exq.push_back(model(v, 1170));
            step();
            if (acc_now) begin
                v       = 16'($urandom);
                dif.inp = v;
            end
        end
        check("b2b_count", nres, 4);
        dif.in_valid = 1'b0;
        step();
        dif.out_ready = 1'b0;
        step();

        // Large intercept: final sum exceeds the 13-bit range.
        bif.inp      = 16'hFF00;
        bif.in_valid = 1'b1;
        step();
        bif.in_valid = 1'b0;
        k = 0;
        while (!bif.out_valid && k < 20) begin
            step();
            k++;
        end
        check("bias_latency", k, 4);
`ifdef SVM_SEQ_SAT_EN
        check("bias_out", int'($signed(bif.out)), 4095);
        check("bias_class", int'(bif.out_class), 1);
`else
        check("bias_out", int'($signed(bif.out)), -2002);
        check("bias_class", int'(bif.out_class), 0);
`endif
        check("bias_model", int'($signed(bif.out)), model(16'hFF00, 4000));
        bif.out_ready = 1'b1;
        step();
        bif.out_ready = 1'b0;
        check("bias_in_ready", int'(bif.in_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
